// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: per-register in-flight write counters drive stall/issue.
// Optional `SCOREBOARD_WB_BYPASS_EN lets a consumer issue in the cycle its last producer retires.
module hazard_scoreboard #(
   parameter int unsigned NREGS  = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned CNT_W  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [ADDR_W-1:0] id_rs1_addr,
   input  logic [ADDR_W-1:0] id_rs2_addr,
   input  logic              id_uses_rs1,
   input  logic              id_uses_rs2,
   input  logic [ADDR_W-1:0] id_rd_addr,
   input  logic              id_RegWrite,
   input  logic              flush,
   input  logic [ADDR_W-1:0] MEM_WB_rd_addr,
   input  logic              MEM_WB_RegWrite,
   output logic              stall,
   output logic              issue_fire,
   output logic [NREGS-1:0]  busy_vec,
   output logic              underflow_err
);

   localparam logic [CNT_W-1:0] CntMax = '1;

   logic [CNT_W-1:0] cnt_q [NREGS];
   logic [CNT_W-1:0] cnt_d [NREGS];
   logic             underflow_q, underflow_d;
   logic [NREGS-1:0] busy, rel, inc;
   logic             haz1, haz2, sat, retire_zero;

   // busy[0] is forced low, so x0 never hazards, saturates or releases.
   always_comb begin
      busy = '0;
      rel  = '0;
      inc  = '0;
      for (int r = 1; r < NREGS; r++) begin
         busy[r] = (cnt_q[r] != '0);
         rel[r]  = MEM_WB_RegWrite && (MEM_WB_rd_addr == ADDR_W'(r)) && (cnt_q[r] != '0);
         inc[r]  = issue_fire && id_RegWrite && (id_rd_addr == ADDR_W'(r));
      end
   end

`ifdef SCOREBOARD_WB_BYPASS_EN
   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
   logic [CNT_W-1:0] cnt_rs1, cnt_rs2;
   assign cnt_rs1 = cnt_q[id_rs1_addr];
   assign cnt_rs2 = cnt_q[id_rs2_addr];
   // The last pending write retiring now is read from the write-first register file.
   assign haz1 = id_uses_rs1 && busy[id_rs1_addr] && !(rel[id_rs1_addr] && cnt_rs1 == CntOne);
   assign haz2 = id_uses_rs2 && busy[id_rs2_addr] && !(rel[id_rs2_addr] && cnt_rs2 == CntOne);
`else
   assign haz1 = id_uses_rs1 && busy[id_rs1_addr];
   assign haz2 = id_uses_rs2 && busy[id_rs2_addr];
`endif

   assign sat = id_RegWrite && busy[id_rd_addr] && (cnt_q[id_rd_addr] == CntMax)
                && !rel[id_rd_addr];

   assign stall      = id_valid && !flush && (haz1 || haz2 || sat);
   assign issue_fire = id_valid && !flush && !stall;

   assign retire_zero = MEM_WB_RegWrite && (MEM_WB_rd_addr != '0)
                        && (cnt_q[MEM_WB_rd_addr] == '0);

   always_comb begin
      for (int r = 0; r < NREGS; r++) begin
         cnt_d[r] = cnt_q[r];
         if (inc[r] && !rel[r]) begin
            cnt_d[r] = cnt_q[r] + 1'b1;
         end else if (!inc[r] && rel[r]) begin
            cnt_d[r] = cnt_q[r] - 1'b1;
         end
      end
      underflow_d = underflow_q || retire_zero;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NREGS; r++) begin
            cnt_q[r] <= '0;
         end
         underflow_q <= 1'b0;
      end else begin
         for (int r = 0; r < NREGS; r++) begin
            cnt_q[r] <= cnt_d[r];
         end
         underflow_q <= underflow_d;
      end
   end

   assign busy_vec      = busy;
   assign underflow_err = underflow_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed plan plus random traffic against a pending-write list model.
// Expectations queue per cycle; a negedge monitor pops and compares.
module tb_hazard_scoreboard;

   localparam int CntMax = 3;
`ifdef SCOREBOARD_WB_BYPASS_EN
   localparam logic RetireCycleFire = 1'b1;
`else
   localparam logic RetireCycleFire = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid, id_uses_rs1, id_uses_rs2, id_RegWrite, flush, MEM_WB_RegWrite;
   logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr, MEM_WB_rd_addr;
   logic        stall, issue_fire, underflow_err;
   logic [31:0] busy_vec;

   always #5 clk = ~clk;

   hazard_scoreboard dut (
      .clk             (clk),
      .rst             (rst),
      .id_valid        (id_valid),
      .id_rs1_addr     (id_rs1_addr),
      .id_rs2_addr     (id_rs2_addr),
      .id_uses_rs1     (id_uses_rs1),
      .id_uses_rs2     (id_uses_rs2),
      .id_rd_addr      (id_rd_addr),
      .id_RegWrite     (id_RegWrite),
      .flush           (flush),
      .MEM_WB_rd_addr  (MEM_WB_rd_addr),
      .MEM_WB_RegWrite (MEM_WB_RegWrite),
      .stall           (stall),
      .issue_fire      (issue_fire),
      .busy_vec        (busy_vec),
      .underflow_err   (underflow_err)
   );

   typedef struct {
      logic        stall;
      logic        fire;
      logic [31:0] busy;
      logic        uf;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   pend[$];   // destinations of issued-but-not-retired writes
   bit   m_uf;
   bit   nx_fire;
   int   total = 0;
   int   bad   = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic int cnt_of(int a);
      int c = 0;
      foreach (pend[i]) if (pend[i] == a) c++;
      return c;
   endfunction

   function automatic bit rel_of(int a);
      return MEM_WB_RegWrite && (int'(MEM_WB_rd_addr) == a) && (a != 0) && (cnt_of(a) != 0);
   endfunction

   function automatic bit haz_of(bit uses, int a);
      bit h;
      h = uses && (a != 0) && (cnt_of(a) != 0);
      if (RetireCycleFire && rel_of(a) && cnt_of(a) == 1) h = 1'b0;
      return h;
   endfunction

   // Called at posedge+1: apply inputs, queue expected outputs for this cycle.
   task automatic drive(bit v, int r1, bit u1, int r2, bit u2, int rd, bit rw, bit fl,
                        int wrd, bit wwe);
      exp_t e;
      bit   sat;
      id_valid = v;  id_rs1_addr = 5'(r1); id_uses_rs1 = u1;
      id_rs2_addr = 5'(r2); id_uses_rs2 = u2;
      id_rd_addr = 5'(rd); id_RegWrite = rw; flush = fl;
      MEM_WB_rd_addr = 5'(wrd); MEM_WB_RegWrite = wwe;
      sat     = rw && (rd != 0) && (cnt_of(rd) == CntMax) && !rel_of(rd);
      e.stall = v && !fl && (haz_of(u1, r1) || haz_of(u2, r2) || sat);
      e.fire  = v && !fl && !e.stall;
      e.busy  = '0;
      for (int a = 1; a < 32; a++) e.busy[a] = (cnt_of(a) != 0);
      e.uf    = m_uf;
      exp_q.push_back(e);
      nx_fire = e.fire;
      #1;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Clock edge: retire one pending write, record underflow, add the issued write.
   task automatic adv();
      int wr    = int'(MEM_WB_rd_addr);
      int rd    = int'(id_rd_addr);
      bit rl    = rel_of(wr);
      bit ufh   = MEM_WB_RegWrite && (wr != 0) && (cnt_of(wr) == 0);
      bit add   = nx_fire && id_RegWrite && (rd != 0);
      @(posedge clk);
      if (rl) begin
         for (int i = 0; i < pend.size(); i++) begin
            if (pend[i] == wr) begin
               pend.delete(i);
               break;
            end
         end
      end
      if (ufh) m_uf = 1'b1;
      if (add) pend.push_back(rd);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      id_valid = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
      id_rd_addr = 0; id_RegWrite = 0; flush = 0; MEM_WB_rd_addr = 0; MEM_WB_RegWrite = 0;
      pend.delete();
      m_uf = 1'b0;
      #1;
      chk("rst_busy", busy_vec, 0);
      chk("rst_stall", stall, 0);
      chk("rst_fire", issue_fire, 0);
      chk("rst_uf", underflow_err, 0);
      @(negedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         chk("mon_stall", stall, mon_e.stall);
         chk("mon_fire", issue_fire, mon_e.fire);
         chk("mon_busy", busy_vec, mon_e.busy);
         chk("mon_uf", underflow_err, mon_e.uf);
      end
   end

   initial begin
      do_reset();

      // Idle after reset.
      idle();
      chk("idle_stall", stall, 0);
      chk("idle_fire", issue_fire, 0);
      adv();

      // RAW on x5.
      drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
      chk("issue5_fire", issue_fire, 1);
      adv();
      drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
      chk("raw_stall", stall, 1);
      chk("raw_busy5", busy_vec[5], 1);
      adv();
      drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
      chk("raw_stall2", stall, 1);
      adv();
      drive(1, 5, 1, 0, 0, 0, 0, 0, 5, 1);
      chk("raw_retire_fire", issue_fire, RetireCycleFire);
      adv();
      drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
      chk("raw_after_fire", issue_fire, 1);
      chk("raw_after_busy5", busy_vec[5], 0);
      adv();

      // x0 is never tracked.
      drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      chk("x0_issue_stall", stall, 0);
      adv();
      drive(1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
      chk("x0_read_stall", stall, 0);
      adv();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      adv();
      idle();
      chk("x0_busy", busy_vec, 0);
      chk("x0_uf", underflow_err, 0);
      adv();

      // Simultaneous inc/dec on x7.
      drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
      adv();
      drive(1, 0, 0, 0, 0, 7, 1, 0, 7, 1);
      chk("incdec_fire", issue_fire, 1);
      adv();
      idle();
      chk("incdec_busy7", busy_vec[7], 1);
      adv();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 7, 1);
      adv();
      idle();
      chk("incdec_drained7", busy_vec[7], 0);
      chk("incdec_uf", underflow_err, 0);
      adv();

      // Saturation of x3.
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
         chk("sat_fill_fire", issue_fire, 1);
         adv();
      end
      drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
      chk("sat_stall", stall, 1);
      adv();
      drive(1, 0, 0, 0, 0, 3, 1, 0, 3, 1);
      chk("sat_release_fire", issue_fire, 1);
      adv();

      // Underflow on x9 is sticky.
      drive(0, 0, 0, 0, 0, 0, 0, 0, 9, 1);
      chk("uf_pre", underflow_err, 0);
      adv();
      idle();
      chk("uf_set", underflow_err, 1);
      adv();
      idle();
      adv();
      idle();
      chk("uf_sticky", underflow_err, 1);
      adv();

      // Flush with a hazard on x3 (count 3).
      drive(1, 3, 1, 0, 0, 3, 1, 1, 0, 0);
      chk("flush_stall", stall, 0);
      chk("flush_fire", issue_fire, 0);
      adv();
      drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
      chk("flush_still_sat", stall, 1);
      adv();
      drive(1, 3, 1, 0, 0, 0, 0, 1, 3, 1);
      adv();
      drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
      chk("flush_retire_applied", issue_fire, 1);
      adv();

      // Asynchronous reset mid-cycle.
      #3;
      do_reset();

      for (int blk = 0; blk < 3; blk++) begin
         for (int c = 0; c < 250; c++) begin
            int wrd;
            bit wwe;
            wwe = ($urandom % 2) == 0;
            if (pend.size() > 0 && ($urandom % 8) != 0) wrd = pend[$urandom % pend.size()];
            else wrd = int'($urandom % 8);
            drive(($urandom % 4) != 0, int'($urandom % 8), $urandom % 2,
                  int'($urandom % 8), $urandom % 2, int'($urandom % 8), ($urandom % 3) != 0,
                  ($urandom % 8) == 0, wrd, wwe);
            adv();
         end
         #2;
         do_reset();
      end

      idle();
      adv();
      chk("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
